// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: architectural register numbers and widths.
package mips_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned RADDR_W = 5;
    localparam int unsigned NREGS   = 1 << RADDR_W;
    localparam int unsigned CNT_W   = 16;

    localparam logic [RADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [RADDR_W-1:0] REG_V0   = 5'd2;
    localparam logic [RADDR_W-1:0] REG_A0   = 5'd4;
    localparam logic [RADDR_W-1:0] REG_GP   = 5'd28;
    localparam logic [RADDR_W-1:0] REG_SP   = 5'd29;
    localparam logic [RADDR_W-1:0] REG_RA   = 5'd31;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Reset value of register n; only $gp and $sp come up non-zero.
    function automatic logic [XLEN-1:0] reg_init(input int unsigned n,
                                                input logic [XLEN-1:0] gp_init,
                                                input logic [XLEN-1:0] sp_init);
        if (n == int'(REG_GP)) begin
            return gp_init;
        end else if (n == int'(REG_SP)) begin
            return sp_init;
        end
        return '0;
    endfunction

    // One-hot write strobe; $0 never receives a strobe.
    function automatic logic [NREGS-1:0] wr_decode(input logic we,
                                                   input logic [RADDR_W-1:0] wa);
        logic [NREGS-1:0] s;
        s = '0;
        if (we) begin
            s[wa] = 1'b1;
        end
        s[REG_ZERO] = 1'b0;
        return s;
    endfunction

endpackage

// File: rtl/reg32_en.sv
// 32-bit register with synchronous active-high reset to INIT and a write enable.
module reg32_en
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] INIT = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [XLEN-1:0] d,
    output logic [XLEN-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= INIT;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_file32.sv
// MIPS architectural register file: 2 combinational read ports, 1 synchronous
// write port, optional same-cycle write forwarding and a saturating write counter.
module reg_file32
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] SP_INIT = 32'h0000_3FFC,
    parameter logic [XLEN-1:0] GP_INIT = 32'h0000_1800,
    parameter bit              BYPASS  = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [RADDR_W-1:0] wa,
    input  logic [XLEN-1:0]    wd,
    input  logic [RADDR_W-1:0] ra1,
    input  logic [RADDR_W-1:0] ra2,
    output logic [XLEN-1:0]    rd1,
    output logic [XLEN-1:0]    rd2,
    output logic [XLEN-1:0]    v0,
    output logic [XLEN-1:0]    a0,
    output logic [CNT_W-1:0]   wr_cnt
);

    logic [NREGS-1:0] strobe;
    logic [XLEN-1:0]  regs [NREGS];
    logic             commit;
    logic             fwd1;
    logic             fwd2;

    always_comb begin
        strobe = wr_decode(we, wa);
    end

    // Bit 0 of the strobe is always clear, so this excludes $0 writes.
    assign commit = |strobe;

    assign regs[0] = '0;

    for (genvar i = 1; i < NREGS; i++) begin : g_regs
        localparam logic [XLEN-1:0] INIT_I = reg_init(i, GP_INIT, SP_INIT);

        reg32_en #(
            .INIT (INIT_I)
        ) u_reg (
            .clk (clk),
            .rst (rst),
            .en  (strobe[i]),
            .d   (wd),
            .q   (regs[i])
        );
    end

    always_comb begin
        fwd1 = BYPASS && we && (wa != REG_ZERO) && (wa == ra1);
        fwd2 = BYPASS && we && (wa != REG_ZERO) && (wa == ra2);
    end

    always_comb begin
        rd1 = (ra1 == REG_ZERO) ? '0 : regs[ra1];
        if (fwd1) begin
            rd1 = wd;
        end
    end

    always_comb begin
        rd2 = (ra2 == REG_ZERO) ? '0 : regs[ra2];
        if (fwd2) begin
            rd2 = wd;
        end
    end

    // Syscall unit samples committed state only, so no forwarding here.
    assign v0 = regs[REG_V0];
    assign a0 = regs[REG_A0];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt <= '0;
        end else if (commit && (wr_cnt != CNT_MAX)) begin
            wr_cnt <= wr_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_file32.sv
// Directed self-checking bench for reg_file32, with and without write forwarding.
module tb_reg_file32;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;

    logic [31:0] b_rd1, b_rd2, b_v0, b_a0;
    logic [15:0] b_cnt;
    logic [31:0] n_rd1, n_rd2, n_v0, n_a0;
    logic [15:0] n_cnt;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    reg_file32 #(
        .SP_INIT (32'h0000_3FFC),
        .GP_INIT (32'h0000_1800),
        .BYPASS  (1'b1)
    ) u_byp (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .wa     (wa),
        .wd     (wd),
        .ra1    (ra1),
        .ra2    (ra2),
        .rd1    (b_rd1),
        .rd2    (b_rd2),
        .v0     (b_v0),
        .a0     (b_a0),
        .wr_cnt (b_cnt)
    );

    reg_file32 #(
        .SP_INIT (32'h0000_3FFC),
        .GP_INIT (32'h0000_1800),
        .BYPASS  (1'b0)
    ) u_nob (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .wa     (wa),
        .wd     (wd),
        .ra1    (ra1),
        .ra2    (ra2),
        .rd1    (n_rd1),
        .rd2    (n_rd2),
        .v0     (n_v0),
        .a0     (n_a0),
        .wr_cnt (n_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance one edge; inputs settle and outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] reset_val(input int n);
        if (n == 28) return 32'h0000_1800;
        if (n == 29) return 32'h0000_3FFC;
        return 32'h0;
    endfunction

    initial begin
        rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
        tick();
        rst = 1'b0;
        #1;

        // Reset state sweep
        for (int n = 0; n < 32; n++) begin
            ra1 = 5'(n);
            ra2 = 5'(31 - n);
            #1;
            check($sformatf("rst_rd1_%0d", n), b_rd1, reset_val(n));
            check($sformatf("rst_rd2_%0d", 31 - n), b_rd2, reset_val(31 - n));
            check($sformatf("rst_nob_rd1_%0d", n), n_rd1, reset_val(n));
        end
        check("rst_cnt", {16'h0, b_cnt}, 32'h0);
        check("rst_v0", b_v0, 32'h0);
        check("rst_a0", b_a0, 32'h0);

        // Write every register, then read back
        for (int n = 1; n < 32; n++) begin
            we = 1'b1; wa = 5'(n); wd = 32'hA5A5_0000 | n;
            tick();
        end
        we = 1'b0;
        for (int n = 1; n < 32; n++) begin
            ra1 = 5'(n);
            ra2 = 5'(n);
            #1;
            check($sformatf("wr_rd1_%0d", n), b_rd1, 32'hA5A5_0000 | n);
            check($sformatf("wr_rd2_%0d", n), b_rd2, 32'hA5A5_0000 | n);
            check($sformatf("wr_nob_rd2_%0d", n), n_rd2, 32'hA5A5_0000 | n);
        end
        check("wr_cnt31", {16'h0, b_cnt}, 32'd31);
        check("wr_nob_cnt31", {16'h0, n_cnt}, 32'd31);
        check("wr_v0", b_v0, 32'hA5A5_0002);
        check("wr_a0", b_a0, 32'hA5A5_0004);

        // $zero write is discarded
        we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; ra1 = 5'd0; ra2 = 5'd0;
        #1;
        check("zero_pre_byp", b_rd1, 32'h0);
        check("zero_pre_nob", n_rd1, 32'h0);
        tick();
        we = 1'b0;
        #1;
        check("zero_post", b_rd1, 32'h0);
        check("zero_cnt", {16'h0, b_cnt}, 32'd31);

        // Forwarding
        we = 1'b1; wa = 5'd5; wd = 32'h1111;
        tick();
        we = 1'b1; wa = 5'd5; wd = 32'h2222; ra1 = 5'd5; ra2 = 5'd5;
        #1;
        check("byp_rd1_pre", b_rd1, 32'h2222);
        check("byp_rd2_pre", b_rd2, 32'h2222);
        check("nob_rd1_pre", n_rd1, 32'h1111);
        check("nob_rd2_pre", n_rd2, 32'h1111);
        tick();
        we = 1'b0;
        #1;
        check("nob_rd1_post", n_rd1, 32'h2222);
        check("byp_rd1_post", b_rd1, 32'h2222);
        check("byp_cnt33", {16'h0, b_cnt}, 32'd33);

        // Ports forward independently
        we = 1'b1; wa = 5'd5; wd = 32'h3333; ra1 = 5'd6; ra2 = 5'd5;
        #1;
        check("indep_rd1", b_rd1, 32'hA5A5_0006);
        check("indep_rd2", b_rd2, 32'h3333);
        tick();

        // v0 shows committed state only
        we = 1'b1; wa = 5'd2; wd = 32'h0000_BEEF; ra1 = 5'd2;
        #1;
        check("v0_pre", b_v0, 32'hA5A5_0002);
        check("v0_rd1_fwd", b_rd1, 32'h0000_BEEF);
        tick();
        we = 1'b0;
        #1;
        check("v0_post", b_v0, 32'h0000_BEEF);
        check("cnt35", {16'h0, b_cnt}, 32'd35);

        // Reset beats a simultaneous write
        rst = 1'b1; we = 1'b1; wa = 5'd2; wd = 32'h7; ra1 = 5'd2;
        #1;
        check("rstw_v0_pre", b_v0, 32'h0000_BEEF);
        check("rstw_rd1_fwd", b_rd1, 32'h7);
        check("rstw_cnt_pre", {16'h0, b_cnt}, 32'd35);
        tick();
        rst = 1'b0; we = 1'b0;
        #1;
        check("rstw_v0", b_v0, 32'h0);
        check("rstw_nob_v0", n_v0, 32'h0);
        check("rstw_cnt", {16'h0, b_cnt}, 32'h0);
        ra1 = 5'd29; ra2 = 5'd5;
        #1;
        check("rstw_sp", b_rd1, 32'h0000_3FFC);
        check("rstw_r5", b_rd2, 32'h0);

        // Counter saturation: 65537 writes to $1
        we = 1'b1; wa = 5'd1; wd = 32'hCAFE_0001;
        for (int k = 0; k < 65534; k++) begin
            tick();
        end
        check("sat_fffe", {16'h0, b_cnt}, 32'h0000_FFFE);
        tick();
        check("sat_ffff", {16'h0, b_cnt}, 32'h0000_FFFF);
        tick();
        tick();
        we = 1'b0; ra1 = 5'd1;
        #1;
        check("sat_hold", {16'h0, b_cnt}, 32'h0000_FFFF);
        check("sat_nob_hold", {16'h0, n_cnt}, 32'h0000_FFFF);
        check("sat_r1", b_rd1, 32'hCAFE_0001);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
